// File: rtl/muldiv_sequencer.sv
// HI/LO owner for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO: shift-add multiply / restoring divide, WIDTH+1 busy cycles.
// stall = busy & (mdReq | rdHiLo); optional MULDIV_FAST_MUL_EN makes multiplies single-cycle at accept.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdReq,
    input  logic [2:0]       mdOp,
    input  logic             rdHiLo,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;

    logic             op_mul, op_div, op_signed, accept, accept_seq;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [WIDTH-1:0] quot, rem;

    always_comb begin
        op_mul    = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
        op_div    = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
        op_signed = (mdOp == OP_MULT) || (mdOp == OP_DIV);
        accept    = (state_q == S_IDLE) && mdReq && (op_mul || op_div);
        abs_a     = (op_signed && srcA[WIDTH-1]) ? -srcA : srcA;
        abs_b     = (op_signed && srcB[WIDTH-1]) ? -srcB : srcB;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    // Sign-extending to 2*WIDTH makes the unsigned product equal the signed one mod 2^(2*WIDTH).
    always_comb begin
        if (op_signed)
            fast_prod = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
        else
            fast_prod = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};
        accept_seq = accept && op_div;
    end
`else
    always_comb begin
        accept_seq = accept;
    end
`endif

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};
        quot      = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mdReq && mdOp == OP_MTHI) hi_d = srcA;
                if (mdReq && mdOp == OP_MTLO) lo_d = srcA;
`ifdef MULDIV_FAST_MUL_EN
                if (accept && op_mul) {hi_d, lo_d} = fast_prod;
`endif
                if (accept_seq) begin
                    state_d    = S_RUN;
                    cnt_d      = CW'(WIDTH - 1);
                    is_div_d   = op_div;
                    neg_res_d  = op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                    neg_rem_d  = op_signed && srcA[WIDTH-1];
                    div_zero_d = op_div && (srcB == '0);
                    acc_d      = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                    opnd_d     = op_div ? abs_b : abs_a;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                if (cnt_q == '0) state_d = S_FIXUP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    // Divide by zero leaves rem = |dividend|, so the hi fixup restores the original srcA.
                    lo_d = div_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -quot : quot);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign stall = busy_q & (mdReq | rdHiLo);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs a shift-add multiply or restoring divide over WIDTH cycles. While the operation is in flight it raises a stall so that any later HI/LO access or new multiply/divide waits in EX. It sits beside the ALU, and the decoder drives its operation code the same way it drives aluOpD.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mdReq  input  1  valid multiply/divide/move-to operation in EX this cycle
- mdOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- rdHiLo  input  1  MFHI/MFLO present in EX this cycle
- srcA  input  WIDTH  rs value (dividend / multiplicand / move source)
- srcB  input  WIDTH  rt value (divisor / multiplier)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  sequencer not in IDLE
- stall  output  1  hold IF/ID/EX this cycle; combinational: busy & (mdReq | rdHiLo)

## Operation
- States:
  - IDLE: waits for work.
  - RUN: WIDTH iterations, counter counts down from WIDTH-1 to 0.
  - FIXUP: one cycle of sign correction plus HI/LO write.
- Accept occurs when the state is IDLE, mdReq=1 and mdOp is MULT, MULTU, DIV or DIVU. On accept:
  - Latch operands. For MULT and DIV, latch absolute values plus the sign flags negRes = signA^signB and negRem = signA.
  - For MULTU and DIVU, both flags are 0.
  - Go to RUN.
- MTHI/MTLO in IDLE write srcA into hi or lo at that edge. No state change.
- RUN, multiply: one shift-add step per cycle. The 2*WIDTH-bit accumulator ends holding the unsigned product.
- RUN, divide: one restoring step per cycle over a (WIDTH+1)-bit partial remainder. It ends with an unsigned quotient and remainder.
- FIXUP, multiply: {hi,lo} = negRes ? -product : product, computed mod 2^(2*WIDTH).
- FIXUP, divide: lo = negRes ? -quot : quot, and hi = negRem ? -rem : rem. Then return to IDLE.
- Divide by zero: completes with normal latency. hi = srcA as latched (original signed value), lo = all ones. No sign fixup is applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF) gives lo=0x80000000, hi=0. No exception is raised.
- Operations arriving while busy are not accepted, because stall holds them in EX. Accept happens on the first cycle busy=0.
- mdReq with mdOp none or reserved: no effect.
- rst: state→IDLE, counter→0, hi=lo=0, busy=0. A reset mid-RUN discards the operation and leaves HI/LO at 0.

## Timing
- Reset values: hi=0, lo=0, busy=0, stall=0.
- Accept edge = end of cycle N.
  - RUN occupies cycles N+1 to N+WIDTH.
  - FIXUP occupies cycle N+WIDTH+1, and hi/lo update at its closing edge.
  - New hi/lo are visible from cycle N+WIDTH+2.
- busy is high from cycle N+1 through N+WIDTH+1 inclusive, which is WIDTH+1 cycles.
- MFHI/MFLO in the FIXUP cycle stalls. It reads the new value one cycle later.
- MTHI/MTLO latency: visible the cycle after the accept edge. busy is never raised.
- stall has no register delay; it is asserted in the same cycle as the conflicting request.
- Counter width is $clog2(WIDTH). RUN exits when the counter equals 0 at the edge.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational signed/unsigned product.
  - hi/lo are written at the accept edge, with no RUN or FIXUP, and busy stays 0.
  - DIV/DIVU are unchanged.
- Not defined: all multiplies use the WIDTH-cycle shift-add path with the timing above.

## Test plan
- MULT srcA=0xFFFFFFFD (-3), srcB=7 → after WIDTH+2 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly WIDTH+1 cycles.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands → lo=0x7FFFFFFC, hi=1.
- DIVU srcA=0x12345678, srcB=0 → lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, then MFHI asserted every cycle → stall=1 until busy drops; first unstalled read sees hi=0xFFFFFFFE, lo=1; a back-to-back MTLO 0x55 is accepted the first cycle busy=0.
- Assert rst mid-RUN of DIV → next cycle busy=0, hi=lo=0; a following MTHI 0xA5A5A5A5 gives hi=0xA5A5A5A5 one cycle later.
- With MULDIV_FAST_MUL_EN: MULT 6×-2 → hi=0xFFFFFFFF, lo=0xFFFFFFF4 the cycle after accept, busy never 1.
